// File: rtl/timer_pkg.sv
// Shared types and defaults for the loadable down-timer.
// Count-path select codes are driven by the FSM and decoded by the datapath.
package timer_pkg;

   localparam int TIMER_WIDTH = 4;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      RUN  = 2'b01,
      DONE = 2'b10
   } timer_state_t;

   typedef enum logic [1:0] {
      SEL_HOLD   = 2'b00,
      SEL_LOAD   = 2'b01,
      SEL_RELOAD = 2'b10,
      SEL_DEC    = 2'b11
   } count_sel_t;

endpackage

// File: rtl/down_timer_fsm.sv
// Control FSM for down_timer: resolves stop > start > load > countdown each edge
// and tells the datapath what to do with count.
//
//   state | meaning
//   ------+---------------------------------------------------------------
//   IDLE  | stopped; count holds, load also copies load_val into count
//   RUN   | counting down; at zero either reloads or ends the one-shot
//   DONE  | one-shot finished; count holds 0 until load/start
module down_timer_fsm
   import timer_pkg::*;
(
   input  logic       clk,
   input  logic       reset_n,
   input  logic       load,
   input  logic       start,
   input  logic       stop,
   input  logic       auto_reload,
   input  logic       count_zero,
   input  logic       count_one,
   input  logic       reload_zero,
   input  logic       load_val_zero,
   output count_sel_t count_sel,
   output logic       busy,
   output logic       done,
   output logic       tc_pulse
);

   timer_state_t state_q;
   timer_state_t state_nxt;
   logic         tc_nxt;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= IDLE;
         busy     <= 1'b0;
         done     <= 1'b0;
         tc_pulse <= 1'b0;
      end else begin
         state_q  <= state_nxt;
         busy     <= (state_nxt == RUN);
         done     <= (state_nxt == DONE);
         tc_pulse <= tc_nxt;
      end
   end

   // tc_nxt is asserted exactly when the next state is RUN and the next count is 0
   always_comb begin
      state_nxt = state_q;
      count_sel = SEL_HOLD;
      tc_nxt    = 1'b0;
      if (stop) begin
         if (state_q != IDLE) begin
            state_nxt = IDLE;
         end
      end else if (start) begin
         state_nxt = RUN;
         if (load) begin
            count_sel = SEL_LOAD;
            tc_nxt    = load_val_zero;
         end else begin
            count_sel = SEL_RELOAD;
            tc_nxt    = reload_zero;
         end
      end else if (load && (state_q != RUN)) begin
         state_nxt = IDLE;
         count_sel = SEL_LOAD;
      end else if (state_q == RUN) begin
         if (!count_zero) begin
            count_sel = SEL_DEC;
            tc_nxt    = count_one;
         end else if (auto_reload) begin
            count_sel = SEL_RELOAD;
            tc_nxt    = reload_zero;
         end else begin
            state_nxt = DONE;
         end
      end else if (state_q != DONE) begin
         state_nxt = IDLE;
      end
   end

endmodule

// File: rtl/down_timer.sv
// Loadable programmable down-timer: one-shot or auto-reload, with a one-cycle
// terminal-count strobe. Holds the reload register and count datapath.
module down_timer
   import timer_pkg::*;
#(
   parameter int WIDTH = TIMER_WIDTH
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             start,
   input  logic             stop,
   input  logic             auto_reload,
   output logic [WIDTH-1:0] count,
   output logic             busy,
   output logic             tc_pulse,
   output logic             done
);

   logic [WIDTH-1:0] reload_reg;
   logic [WIDTH-1:0] count_nxt;
   count_sel_t       count_sel;
   logic             count_zero;
   logic             count_one;
   logic             reload_zero;
   logic             load_val_zero;

   assign count_zero    = (count == '0);
   assign count_one     = (count == WIDTH'(1));
   assign reload_zero   = (reload_reg == '0);
   assign load_val_zero = (load_val == '0);

   down_timer_fsm u_fsm (
      .clk           (clk),
      .reset_n       (reset_n),
      .load          (load),
      .start         (start),
      .stop          (stop),
      .auto_reload   (auto_reload),
      .count_zero    (count_zero),
      .count_one     (count_one),
      .reload_zero   (reload_zero),
      .load_val_zero (load_val_zero),
      .count_sel     (count_sel),
      .busy          (busy),
      .done          (done),
      .tc_pulse      (tc_pulse)
   );

   // SEL_DEC is only issued for a non-zero count, so the subtraction never wraps
   always_comb begin
      count_nxt = count;
      case (count_sel)
         SEL_LOAD:   count_nxt = load_val;
         SEL_RELOAD: count_nxt = reload_reg;
         SEL_DEC:    count_nxt = count - WIDTH'(1);
         default:    count_nxt = count;
      endcase
   end

   // reload_reg is a plain config write; it is not gated by stop/start priority
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         reload_reg <= '0;
         count      <= '0;
      end else begin
         if (load) begin
            reload_reg <= load_val;
         end
         count <= count_nxt;
      end
   end

endmodule
